// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file widths and the writeback entry type.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic              live;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_kill_fifo.sv
// wb_kill_fifo: load-result FIFO whose entries can be killed by a younger write to the same register.
module wb_kill_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  wb_entry_t              i_push_entry,
  input  logic                   i_pop,
  input  logic                   i_kill_en,
  input  logic [ADDR_W-1:0]      i_kill_rd,
  output wb_entry_t              o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [2**ADDR_W-1:0]   o_busy_mask
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  wb_entry_t        r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i].live <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (i_kill_en && r_mem[i].rd == i_kill_rd) r_mem[i].live <= 1'b0;
      // a popped slot is cleared so the mask only ever sees occupied entries
      if (i_pop) begin
        r_mem[r_head].live <= 1'b0;
        r_head             <= r_head + 1'b1;
      end
      if (i_push) begin
        r_mem[r_tail] <= i_push_entry;
        r_tail        <= r_tail + 1'b1;
      end
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  assign o_head  = r_mem[r_head];
  assign o_count = r_count;
  always_comb begin
    o_busy_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (r_mem[i].live) o_busy_mask[r_mem[i].rd] = 1'b1;
    o_busy_mask[0] = 1'b0;
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and buffered load results into one registered register-file write per cycle.
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_rd,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [ADDR_W-1:0]      ld_rd,
  input  logic [DATA_W-1:0]      ld_data,
  output logic [ADDR_W-1:0]      write_reg,
  output logic [DATA_W-1:0]      write_data,
  output logic                   regWrite,
  output logic [2**ADDR_W-1:0]   busy_mask,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic      w_alu_wr;
  logic      w_push;
  logic      w_pop;
  wb_entry_t w_head;
  wb_entry_t w_push_entry;
  wb_entry_t w_nxt;
  assign w_alu_wr     = alu_valid && alu_rd != REG_ZERO;
  assign ld_ready     = !rst && fifo_count < CW'(DEPTH);
  assign w_push       = ld_valid && ld_ready && ld_rd != REG_ZERO;
  assign w_pop        = !w_alu_wr && fifo_count != '0;
  // the ALU result is younger than a load arriving alongside it
  assign w_push_entry = wb_entry_t'{live: !(w_alu_wr && ld_rd == alu_rd), rd: ld_rd, data: ld_data};
  assign w_nxt        = w_alu_wr ? wb_entry_t'{live: 1'b1, rd: alu_rd, data: alu_data} :
                        (w_pop && w_head.live) ? w_head :
                        wb_entry_t'{live: 1'b0, rd: write_reg, data: write_data};
  wb_kill_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_kill_en    (w_alu_wr),
    .i_kill_rd    (alu_rd),
    .o_head       (w_head),
    .o_count      (fifo_count),
    .o_busy_mask  (busy_mask)
  );
  always_ff @(posedge clk) begin
    if (rst) {regWrite, write_reg, write_data} <= '0;
    else     {regWrite, write_reg, write_data} <= w_nxt;
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and random stimulus scored against a queue-based writeback model.
module tb_wb_arbiter;
  import cpu_pkg::*;
  localparam int DEPTH = 4;
  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] mask;
    int          cnt;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        regWrite;
  logic [31:0] busy_mask;
  logic [2:0]  fifo_count;
  wb_entry_t   mq[$];
  exp_t        sb[$];
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic [31:0] m_rf[32];
  logic [31:0] d_rf[32];
  int          n_chk = 0;
  int          n_err = 0;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .write_reg(write_reg), .write_data(write_data), .regWrite(regWrite),
    .busy_mask(busy_mask), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ldd);
    logic        acc;
    logic        aw;
    logic        we;
    logic [31:0] mask;
    wb_entry_t   h;
    @(negedge clk);
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_data = ldd;
    #1;
    acc = !r && mq.size() < DEPTH;
    chk("ld_ready", 64'(ld_ready), 64'(acc));
    acc = acc && lv;
    we  = 1'b0;
    if (r) begin
      mq.delete();
      m_reg  = '0;
      m_data = '0;
    end else begin
      aw = av && ard != 5'd0;
      if (aw) begin
        we = 1'b1; m_reg = ard; m_data = ad;
        foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
      end else if (mq.size() > 0) begin
        h  = mq.pop_front();
        we = h.live;
        if (h.live) begin m_reg = h.rd; m_data = h.data; end
      end
      if (we) m_rf[m_reg] = m_data;
      if (acc && lrd != 5'd0) mq.push_back('{live: !(aw && lrd == ard), rd: lrd, data: ldd});
    end
    mask = '0;
    foreach (mq[i]) if (mq[i].live) mask[mq[i].rd] = 1'b1;
    sb.push_back('{we: we, rd: m_reg, data: m_data, mask: mask, cnt: mq.size()});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("regWrite", 64'(regWrite), 64'(e.we));
        chk("write_reg", 64'(write_reg), 64'(e.rd));
        chk("write_data", 64'(write_data), 64'(e.data));
        chk("busy_mask", 64'(busy_mask), 64'(e.mask));
        chk("fifo_count", 64'(fifo_count), 64'(e.cnt));
        if (regWrite === 1'b1) d_rf[write_reg] = write_data;
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin m_rf[i] = '0; d_rf[i] = '0; end
    m_reg = '0; m_data = '0;
    rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cyc(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    idle(2);
    chk("alu_r5", 64'(d_rf[5]), 64'h1234);
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, 5'd20, 32'(i), 1'b1, 5'(i), 32'(i * 17));
    cyc(1'b0, 1'b1, 5'd20, 32'd9, 1'b1, 5'd6, 32'h66);
    idle(6);
    for (int i = 1; i <= 4; i++) chk("fill_order", 64'(d_rf[i]), 64'(i * 17));
    chk("full_reject_r6", 64'(d_rf[6]), 64'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
    cyc(1'b0, 1'b1, 5'd7, 32'h99, 1'b0, 5'd0, 32'd0);
    idle(3);
    chk("waw_r7", 64'(d_rf[7]), 64'h99);
    cyc(1'b0, 1'b1, 5'd9, 32'h66, 1'b1, 5'd9, 32'h55);
    idle(3);
    chk("same_cycle_r9", 64'(d_rf[9]), 64'h66);
    cyc(1'b0, 1'b1, 5'd20, 32'd1, 1'b1, 5'd10, 32'hA0);
    cyc(1'b0, 1'b1, 5'd20, 32'd2, 1'b1, 5'd11, 32'hB0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    chk("alu_rd0_r11", 64'(d_rf[11]), 64'hB0);
    cyc(1'b0, 1'b1, 5'd20, 32'd3, 1'b1, 5'd12, 32'hC0);
    cyc(1'b0, 1'b1, 5'd20, 32'd4, 1'b1, 5'd13, 32'hD0);
    cyc(1'b0, 1'b1, 5'd20, 32'd5, 1'b1, 5'd14, 32'hE0);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle(4);
    chk("rst_drop_r12", 64'(d_rf[12]), 64'd0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(63) == 0, 1'($urandom_range(1)), 5'($urandom_range(7)), $urandom(),
          $urandom_range(9) < 6, 5'($urandom_range(7)), $urandom());
    idle(8);
    @(posedge clk);
    #3;
    chk("sb_drain", 64'(sb.size()), 64'd0);
    for (int i = 0; i < 32; i++) chk("final_rf", 64'(d_rf[i]), 64'(m_rf[i]));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
